mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-ported, multi-cycle memory between the IF-stage instruction fetch and the MEM-stage load/store of the 5-stage pipeline.
- Serialises requests through a small FSM and returns registered read data with a one-cycle ready pulse.
- Drives stall signals that the hazard logic uses to freeze PC, IF/ID and downstream pipeline registers.

Parameters:
LATENCY, 3, cycles the memory needs from a held command to valid m_rdata (legal range 1..15)
ADDR_W, 32, address width
DATA_W, 32, data width

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
if_req  input  1  instruction fetch request; held until if_ready
if_addr  input  ADDR_W  fetch address (current PC)
if_rdata  output  DATA_W  fetched instruction, registered
if_ready  output  1  one-cycle pulse: if_rdata valid
mem_read  input  1  load request; held until mem_ready
mem_write  input  1  store request; held until mem_ready
mem_addr  input  ADDR_W  load/store address (EX/MEM ALU result)
mem_wdata  input  DATA_W  store data
mem_rdata  output  DATA_W  load data, registered
mem_ready  output  1  one-cycle pulse: load/store complete
m_addr  output  ADDR_W  address to memory
m_wdata  output  DATA_W  write data to memory
m_read  output  1  read command to memory
m_write  output  1  write command to memory
m_rdata  input  DATA_W  memory read data, valid in final BUSY cycle
stall_if  output  1  if_req & ~if_ready
stall_mem  output  1  (mem_read | mem_write) & ~mem_ready

Behaviour:
- Reset, sampled at a clk edge, forces the following regardless of state: state=IDLE, count=0, if_ready=0, mem_ready=0, if_rdata=0, mem_rdata=0, m_read=0, m_write=0, m_addr=0, m_wdata=0. An in-flight access is abandoned and produces no ready.
- States: IDLE, BUSY, RESP. Latched owner bit: 0=IF, 1=MEM.
- IDLE behaviour:
  - Any MEM request (mem_read|mem_write) wins and sets owner=MEM.
  - Otherwise an if_req sets owner=IF.
  - On a grant: latch the address, wdata and read/write kind; set count=LATENCY-1; go to BUSY.
  - No request: stay in IDLE.
- BUSY behaviour:
  - m_addr, m_wdata, m_read and m_write are driven from the latched values and held constant for the whole BUSY period.
  - When count != 0, decrement count.
  - When count == 0: capture m_rdata into the owner's rdata register (reads only; a write leaves mem_rdata unchanged), drop the m_* commands next cycle, and go to RESP.
- RESP behaviour: assert the owner's ready for exactly this cycle, then go to IDLE. There is no grant in RESP (one bubble).
- Latency and occupancy:
  - Request to ready is LATENCY+1 cycles.
  - Back-to-back occupancy per access is LATENCY+2 cycles.
  - LATENCY=1 gives a single BUSY cycle.
- Priority:
  - MEM has fixed priority because it is the older instruction.
  - IF cannot starve: a pending MEM request stalls the whole pipe, so no new MEM request can appear until IF progresses.
- Simultaneous read and write on the MEM side is illegal. The write takes precedence, and a simulation assertion fires.
- A request that drops while in BUSY is ignored; the access completes and ready still pulses.
- The address is not changed by the arbiter; alignment is the requester's responsibility.
- Stall usage by the pipeline:
  - stall_mem freezes PC, IF/ID, ID/EX and EX/MEM.
  - stall_if alone freezes PC and injects a NOP into IF/ID.
- The stall outputs are combinational. There is no path from stall to req inside this block.

Optional Feature:
- MEM_ARB_PERF_EN defined:
  - Adds outputs perf_if_stall (32) and perf_mem_stall (32).
  - Each counts the cycles its stall signal is high, saturating at 0xFFFFFFFF.
  - Both clear on reset.
- MEM_ARB_PERF_EN undefined: the counter ports and logic are absent, and behaviour is otherwise identical.

Decomposition:
- Shared package mem_arb_pkg holds:
  - the state enum {IDLE, BUSY, RESP};
  - the owner encoding OWNER_IF/OWNER_MEM;
  - the LATENCY width constant CNT_W=4.
- Sub-module arb_latency_counter: load, decrement, zero flag, synchronous reset. Instantiated once.

Test Plan:
- LATENCY=3, if_req=1, if_addr=0x10, memory returns 0x00A00093 → m_read high for 3 cycles with m_addr=0x10; if_ready pulses on cycle 4 with if_rdata=0x00A00093; stall_if high for cycles 0-3.
- if_req and mem_read asserted in the same cycle, mem_addr=0x200, memory[0x200]=0x55 → MEM is served first (mem_ready at cycle 4, mem_rdata=0x55); the IF grant follows in the cycle after RESP; if_ready at cycle 9.
- mem_write=1, mem_addr=0x40, mem_wdata=0xDEADBEEF → m_write held 3 cycles with those values; mem_ready pulses; mem_rdata is unchanged from its prior value.
- Reset asserted during the second BUSY cycle → next cycle state=IDLE, m_read=0, and no ready pulse ever appears for that access.
- LATENCY=1, continuous if_req → if_ready pulses every 3 cycles.
- MEM_ARB_PERF_EN defined, scenario 2 run → perf_mem_stall=4 and perf_if_stall=9.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the IF/MEM memory port arbiter.
package mem_arb_pkg;

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } state_t;

  localparam logic OWNER_IF  = 1'b0;
  localparam logic OWNER_MEM = 1'b1;

endpackage

// File: rtl/arb_latency_counter.sv
// Down-counter that times the BUSY phase of a memory access.
module arb_latency_counter
  import mem_arb_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_dec,
  output logic             o_zero
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_zero = (r_count == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one multi-cycle memory port between instruction fetch and load/store.
// Define MEM_ARB_PERF_EN to add saturating stall-cycle counters.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int LATENCY = 3,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ready,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_ready,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  output logic              m_read,
  output logic              m_write,
  input  logic [DATA_W-1:0] m_rdata,
  output logic              stall_if,
  output logic              stall_mem
`ifdef MEM_ARB_PERF_EN
  ,
  output logic [31:0]       perf_if_stall,
  output logic [31:0]       perf_mem_stall
`endif
);

  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(LATENCY - 1);

  state_t            r_state;
  state_t            w_next;
  logic              r_owner;
  logic              r_read;
  logic              r_write;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_if_rdata;
  logic [DATA_W-1:0] r_mem_rdata;
  logic              w_mem_req;
  logic              w_grant;
  logic              w_cnt_zero;
  logic              w_busy;
  logic              w_done;
  logic              w_if_ready;
  logic              w_mem_ready;

  assign w_mem_req = mem_read | mem_write;
  assign w_busy    = (r_state == BUSY);
  assign w_grant   = (r_state == IDLE) && (w_mem_req || if_req);
  assign w_done    = w_busy && w_cnt_zero;

  arb_latency_counter u_cnt (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_grant),
    .i_load_val (LOAD_VAL),
    .i_dec      (w_busy),
    .o_zero     (w_cnt_zero)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // RESP never grants, which leaves one bubble between back-to-back accesses.
  always_comb begin
    w_next      = r_state;
    w_if_ready  = 1'b0;
    w_mem_ready = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_mem_req || if_req) begin
          w_next = BUSY;
        end
      end
      BUSY: begin
        if (w_cnt_zero) begin
          w_next = RESP;
        end
      end
      RESP: begin
        w_next      = IDLE;
        w_if_ready  = (r_owner == OWNER_IF);
        w_mem_ready = (r_owner == OWNER_MEM);
      end
      default: w_next = IDLE;
    endcase
  end

  // A simultaneous load and store is resolved as a store.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_owner     <= OWNER_IF;
      r_read      <= 1'b0;
      r_write     <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_if_rdata  <= '0;
      r_mem_rdata <= '0;
    end else if (w_grant) begin
      r_owner <= w_mem_req ? OWNER_MEM : OWNER_IF;
      r_addr  <= w_mem_req ? mem_addr : if_addr;
      r_wdata <= (w_mem_req && mem_write) ? mem_wdata : '0;
      r_read  <= w_mem_req ? ~mem_write : 1'b1;
      r_write <= w_mem_req & mem_write;
    end else if (w_done) begin
      r_read  <= 1'b0;
      r_write <= 1'b0;
      if (r_read && (r_owner == OWNER_MEM)) begin
        r_mem_rdata <= m_rdata;
      end
      if (r_read && (r_owner == OWNER_IF)) begin
        r_if_rdata <= m_rdata;
      end
    end
  end

  assign m_addr    = r_addr;
  assign m_wdata   = r_wdata;
  assign m_read    = r_read;
  assign m_write   = r_write;
  assign if_rdata  = r_if_rdata;
  assign mem_rdata = r_mem_rdata;
  assign if_ready  = w_if_ready;
  assign mem_ready = w_mem_ready;
  assign stall_if  = if_req & ~w_if_ready;
  assign stall_mem = w_mem_req & ~w_mem_ready;

  a_rw_exclusive : assert property (@(posedge clk) disable iff (reset) !(mem_read && mem_write));

`ifdef MEM_ARB_PERF_EN
  logic [31:0] r_perf_if;
  logic [31:0] r_perf_mem;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_perf_if  <= '0;
      r_perf_mem <= '0;
    end else begin
      if (stall_if && (r_perf_if != 32'hFFFF_FFFF)) begin
        r_perf_if <= r_perf_if + 32'd1;
      end
      if (stall_mem && (r_perf_mem != 32'hFFFF_FFFF)) begin
        r_perf_mem <= r_perf_mem + 32'd1;
      end
    end
  end

  assign perf_if_stall  = r_perf_if;
  assign perf_mem_stall = r_perf_mem;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed scenarios, reset abort and random traffic.
// Perf-counter checks are compiled in when MEM_ARB_PERF_EN is defined.
`timescale 1ns/1ps
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ready;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic        m_read;
  logic        m_write;
  logic [31:0] m_rdata;
  logic        stall_if;
  logic        stall_mem;

  logic        if_req1;
  logic [31:0] if_rdata1;
  logic        if_ready1;
  logic [31:0] mem_rdata1;
  logic        mem_ready1;
  logic [31:0] m_addr1;
  logic [31:0] m_wdata1;
  logic        m_read1;
  logic        m_write1;
  logic        stall_if1;
  logic        stall_mem1;

`ifdef MEM_ARB_PERF_EN
  logic [31:0] perf_if_stall;
  logic [31:0] perf_mem_stall;
  logic [31:0] perf_if_stall1;
  logic [31:0] perf_mem_stall1;
`endif

  int checks = 0;
  int passes = 0;
  int cyc = 0;

  logic [31:0] refMem [0:255];
  logic [31:0] wrData [0:255];
  logic        wrValid [0:255] = '{default: 1'b0};
  logic [31:0] ifExpQ [$];
  logic [31:0] memExpQ [$];
  logic [31:0] lastLoad;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_port_arbiter #(.LATENCY(3), .ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .m_addr(m_addr), .m_wdata(m_wdata), .m_read(m_read), .m_write(m_write), .m_rdata(m_rdata),
    .stall_if(stall_if), .stall_mem(stall_mem)
`ifdef MEM_ARB_PERF_EN
    , .perf_if_stall(perf_if_stall), .perf_mem_stall(perf_mem_stall)
`endif
  );

  // Second instance with the shortest latency, fed a constant instruction word.
  mem_port_arbiter #(.LATENCY(1), .ADDR_W(32), .DATA_W(32)) dut1 (
    .clk(clk), .reset(reset),
    .if_req(if_req1), .if_addr(32'h0), .if_rdata(if_rdata1), .if_ready(if_ready1),
    .mem_read(1'b0), .mem_write(1'b0), .mem_addr(32'h0), .mem_wdata(32'h0),
    .mem_rdata(mem_rdata1), .mem_ready(mem_ready1),
    .m_addr(m_addr1), .m_wdata(m_wdata1), .m_read(m_read1), .m_write(m_write1), .m_rdata(32'h13),
    .stall_if(stall_if1), .stall_mem(stall_mem1)
`ifdef MEM_ARB_PERF_EN
    , .perf_if_stall(perf_if_stall1), .perf_mem_stall(perf_mem_stall1)
`endif
  );

  function automatic logic [31:0] initPattern(input logic [7:0] idx);
    if (idx == 8'h04) return 32'h00A0_0093;
    if (idx == 8'h80) return 32'h0000_0055;
    return 32'h1000_0000 + ({24'h0, idx} * 32'h0001_0203);
  endfunction

  always_comb begin
    m_rdata = wrValid[m_addr[9:2]] ? wrData[m_addr[9:2]] : initPattern(m_addr[9:2]);
  end

  always @(posedge clk) begin
    if (m_write) begin
      wrData[m_addr[9:2]]  <= m_wdata;
      wrValid[m_addr[9:2]] <= 1'b1;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic failTimeout(input string name);
    checks++;
    $display("[TB] FAIL %s: got no ready pulse, expected one within 200 cycles", name);
  endtask

  // Scoreboard monitor: every ready pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!reset) begin
      if (if_ready) begin
        if (ifExpQ.size() == 0) checkOutput("if_unexpected_ready", 32'd1, 32'd0);
        else checkOutput("if_rdata", if_rdata, ifExpQ.pop_front());
      end
      if (mem_ready) begin
        if (memExpQ.size() == 0) checkOutput("mem_unexpected_ready", 32'd1, 32'd0);
        else checkOutput("mem_rdata", mem_rdata, memExpQ.pop_front());
      end
      checkOutput("stall_if", 32'(stall_if), 32'(if_req && !if_ready));
      checkOutput("stall_mem", 32'(stall_mem), 32'((mem_read || mem_write) && !mem_ready));
    end
  end

  int lastPulse = -1;
  int pulses1 = 0;
  always @(negedge clk) begin
    if (reset) begin
      lastPulse = -1;
    end else if (if_ready1) begin
      if (pulses1 < 10) begin
        checkOutput("lat1_rdata", if_rdata1, 32'h13);
        if (lastPulse >= 0) checkOutput("lat1_period", 32'(cyc - lastPulse), 32'd3);
        pulses1++;
      end
      lastPulse = cyc;
    end
  end

  task automatic applyReset();
    reset = 1'b1;
    if_req = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    ifExpQ.delete();
    memExpQ.delete();
    lastLoad = '0;
  endtask

  // Issue a fetch at posedge+1 and hold it until the ready pulse.
  task automatic doIf(input logic [31:0] addr, output int lat, output int rdCycles);
    ifExpQ.push_back(refMem[addr[9:2]]);
    if_addr = addr;
    if_req = 1'b1;
    lat = 0;
    rdCycles = 0;
    forever begin
      @(negedge clk);
      if (m_read && m_addr == addr) rdCycles++;
      if (if_ready) break;
      lat++;
      if (lat > 200) begin failTimeout("if_timeout"); break; end
    end
    @(posedge clk); #1;
    if_req = 1'b0;
  endtask

  task automatic doMem(input logic isWrite, input logic [31:0] addr, input logic [31:0] wdata,
                       output int lat, output int wrCycles);
    if (isWrite) begin
      refMem[addr[9:2]] = wdata;
    end else begin
      lastLoad = refMem[addr[9:2]];
    end
    memExpQ.push_back(lastLoad);
    mem_addr = addr;
    mem_wdata = wdata;
    mem_write = isWrite;
    mem_read = !isWrite;
    lat = 0;
    wrCycles = 0;
    forever begin
      @(negedge clk);
      if (m_write && m_addr == addr && m_wdata == wdata) wrCycles++;
      if (mem_ready) break;
      lat++;
      if (lat > 200) begin failTimeout("mem_timeout"); break; end
    end
    @(posedge clk); #1;
    mem_read = 1'b0;
    mem_write = 1'b0;
  endtask

  task automatic applyStimulus();
    fork
      begin : ifProc
        int l, r;
        for (int n = 0; n < 40; n++) begin
          doIf({22'h0, 8'($urandom_range(0, 127)), 2'b00}, l, r);
          repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
        end
      end
      begin : memProc
        int l, w;
        for (int n = 0; n < 40; n++) begin
          doMem(1'($urandom_range(0, 1)), {22'h0, 8'($urandom_range(128, 255)), 2'b00},
                $urandom, l, w);
          repeat ($urandom_range(0, 4)) begin @(posedge clk); #1; end
        end
      end
    join
  endtask

  int latA, cntA, latB, cntB, readyCnt;

  initial begin
    for (int i = 0; i < 256; i++) refMem[i] = initPattern(8'(i));
    if_addr = '0; mem_addr = '0; mem_wdata = '0;
    if_req1 = 1'b1;
    applyReset();

    @(negedge clk);
    checkOutput("rst_if_rdata", if_rdata, 32'h0);
    checkOutput("rst_mem_rdata", mem_rdata, 32'h0);
    checkOutput("rst_m_addr", m_addr, 32'h0);
    checkOutput("rst_m_wdata", m_wdata, 32'h0);
    checkOutput("rst_m_cmd", {30'h0, m_read, m_write}, 32'h0);
    checkOutput("rst_ready", {30'h0, if_ready, mem_ready}, 32'h0);
    @(posedge clk); #1;

    $display("[TB] fetch from 0x10");
    doIf(32'h10, latA, cntA);
    checkOutput("fetch_latency", 32'(latA), 32'd4);
    checkOutput("fetch_m_read_cycles", 32'(cntA), 32'd3);

    $display("[TB] simultaneous load and fetch");
    applyReset();
    fork
      doMem(1'b0, 32'h200, 32'h0, latA, cntA);
      doIf(32'h10, latB, cntB);
    join
    checkOutput("contend_mem_latency", 32'(latA), 32'd4);
    checkOutput("contend_if_latency", 32'(latB), 32'd9);
`ifdef MEM_ARB_PERF_EN
    @(negedge clk);
    checkOutput("perf_mem_stall", perf_mem_stall, 32'd4);
    checkOutput("perf_if_stall", perf_if_stall, 32'd9);
    @(posedge clk); #1;
`endif

    $display("[TB] store then load back");
    doMem(1'b1, 32'h40, 32'hDEAD_BEEF, latA, cntA);
    checkOutput("store_latency", 32'(latA), 32'd4);
    checkOutput("store_m_write_cycles", 32'(cntA), 32'd3);
    doMem(1'b0, 32'h40, 32'h0, latA, cntA);

    $display("[TB] reset during BUSY");
    if_addr = 32'h20;
    if_req = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    if_req = 1'b0;
    lastLoad = '0;
    @(negedge clk);
    checkOutput("abort_m_read", 32'(m_read), 32'd0);
    checkOutput("abort_if_rdata", if_rdata, 32'h0);
    readyCnt = 0;
    repeat (12) begin
      @(negedge clk);
      if (if_ready || mem_ready) readyCnt++;
    end
    checkOutput("abort_no_ready", 32'(readyCnt), 32'd0);
    @(posedge clk); #1;

    $display("[TB] random traffic");
    applyStimulus();
    repeat (3) @(posedge clk);
    checkOutput("if_queue_drained", 32'(ifExpQ.size()), 32'd0);
    checkOutput("mem_queue_drained", 32'(memExpQ.size()), 32'd0);
    checkOutput("lat1_pulses_seen", 32'(pulses1 >= 3), 32'd1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
